// File: rtl/rv32_mod_mem_arbiter.sv
// Shares one registered memory bus between the fetch and load/store ports of the hart.
// Round-robin on ties, one transaction in flight, watchdog converts a silent bus into err.
module rv32_mod_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  localparam logic GRANT_INSTR = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] CNT_LAST =
    TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [3:0]           bus_be_q, bus_be_d;
  logic [31:0]          bus_addr_q, bus_addr_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;

  logic busy, timeout_hit, done_ack, done_err, grant_i, grant_d;

  assign instr_rdata = bus_rdata;
  assign data_rdata  = bus_rdata;

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_be    = bus_be_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  // bus_err outranks bus_ack; the watchdog only fires when the bus stays silent.
  assign busy        = (state_q != ST_IDLE);
  assign timeout_hit = WDOG_EN && (cnt_q == CNT_LAST);
  assign done_err    = busy && (bus_err || (!bus_ack && timeout_hit));
  assign done_ack    = busy && !bus_err && bus_ack;

  // Responses are suppressed during reset so an aborted transaction stays silent.
  assign instr_ack = !reset && (state_q == ST_BUSY_I) && done_ack;
  assign instr_err = !reset && (state_q == ST_BUSY_I) && done_err;
  assign data_ack  = !reset && (state_q == ST_BUSY_D) && done_ack;
  assign data_err  = !reset && (state_q == ST_BUSY_D) && done_err;

  assign grant_d = data_req && (!instr_req || (last_grant_q == GRANT_INSTR));
  assign grant_i = instr_req && !grant_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_be_d     = bus_be_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    if (state_q == ST_IDLE) begin
      if (grant_d) begin
        state_d      = ST_BUSY_D;
        last_grant_d = GRANT_DATA;
        cnt_d        = '0;
        bus_req_d    = 1'b1;
        bus_we_d     = data_we;
        bus_be_d     = data_be;
        bus_addr_d   = data_addr;
        bus_wdata_d  = data_wdata;
      end else if (grant_i) begin
        state_d      = ST_BUSY_I;
        last_grant_d = GRANT_INSTR;
        cnt_d        = '0;
        bus_req_d    = 1'b1;
        bus_we_d     = 1'b0;
        bus_be_d     = 4'hF;
        bus_addr_d   = instr_addr;
      end
    end else if (done_ack || done_err) begin
      state_d   = ST_IDLE;
      bus_req_d = 1'b0;
      bus_we_d  = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_INSTR;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_be_q     <= 4'h0;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_be_q     <= bus_be_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_rv32_mod_mem_arbiter.sv
// Bench for rv32_mod_mem_arbiter: directed vector table, hand-written corner sequences,
// then random traffic compared against a transaction-level reference model.
module tb_rv32_mod_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack, instr_err;
  logic [31:0] instr_rdata;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_ack, data_err;
  logic [31:0] data_rdata;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  rv32_mod_mem_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
    .instr_err(instr_err), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_err(data_err),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // inputs change 1 time unit after the rising edge; outputs are sampled 3 units later
  task automatic sample();
    #3;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; instr_req = 1'b0; instr_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
  endtask

  typedef struct {
    logic        rst, ireq, dreq, dwe;
    logic [3:0]  dbe;
    logic [31:0] iaddr, daddr, dwdata;
    logic        back, berr;
    logic        breq, bwe;
    logic [3:0]  bbe;
    logic [31:0] baddr;
    logic [3:0]  acks;   // {instr_ack, instr_err, data_ack, data_err}
  } vec_t;

  vec_t vecs[17];

  // reference model: who owns the bus, how long it has waited, who won last
  int          m_owner;      // 0 none, 1 fetch, 2 load/store
  int          m_age;
  bit          m_last_data;
  logic        m_breq, m_bwe;
  logic [3:0]  m_bbe;
  logic [31:0] m_baddr, m_bwdata;
  bit          e_ia, e_ie, e_da, e_de;

  task automatic model_eval();
    bit fin_err, fin_ack;
    fin_err = bus_err || (!bus_ack && (TO != 0) && (m_age == TO - 1));
    fin_ack = !bus_err && bus_ack;
    e_ia = !reset && (m_owner == 1) && fin_ack;
    e_ie = !reset && (m_owner == 1) && fin_err;
    e_da = !reset && (m_owner == 2) && fin_ack;
    e_de = !reset && (m_owner == 2) && fin_err;
  endtask

  task automatic model_step();
    int pick;
    pick = 0;
    if (reset) begin
      m_owner = 0; m_age = 0; m_last_data = 1'b0;
      m_breq = 1'b0; m_bwe = 1'b0; m_bbe = 4'h0; m_baddr = 32'h0; m_bwdata = 32'h0;
    end else if (m_owner != 0) begin
      if (e_ia || e_ie || e_da || e_de) begin
        m_owner = 0; m_breq = 1'b0; m_bwe = 1'b0;
      end else begin
        m_age++;
      end
    end else begin
      if (instr_req && data_req) pick = m_last_data ? 1 : 2;
      else if (instr_req)        pick = 1;
      else if (data_req)         pick = 2;
      if (pick == 1) begin
        m_owner = 1; m_age = 0; m_last_data = 1'b0;
        m_breq = 1'b1; m_bwe = 1'b0; m_bbe = 4'hF; m_baddr = instr_addr;
      end else if (pick == 2) begin
        m_owner = 2; m_age = 0; m_last_data = 1'b1;
        m_breq = 1'b1; m_bwe = data_we; m_bbe = data_be; m_baddr = data_addr;
        m_bwdata = data_wdata;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    bit i_done, d_done;

    idle_inputs();
    reset = 1'b1;
    advance();
    advance();

    // rst ireq dreq dwe dbe iaddr daddr dwdata back berr | breq bwe bbe baddr acks
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,4'b0000};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,32'h100,32'h0,32'h0,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,4'b0000};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,32'h100,32'h0,32'h0,1'b0,1'b0, 1'b1,1'b0,4'hF,32'h100,4'b0000};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,32'h100,32'h0,32'h0,1'b0,1'b0, 1'b1,1'b0,4'hF,32'h100,4'b0000};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,32'h100,32'h0,32'h0,1'b1,1'b0, 1'b1,1'b0,4'hF,32'h100,4'b1000};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,1'b0, 1'b0,1'b0,4'hF,32'h100,4'b0000};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,1'b0, 1'b0,1'b0,4'hF,32'h100,4'b0000};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,4'h3,32'h300,32'h2000,32'hDEADBEEF,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,4'b0000};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,4'h3,32'h300,32'h2000,32'hDEADBEEF,1'b0,1'b0, 1'b1,1'b1,4'h3,32'h2000,4'b0000};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b1,4'h3,32'h300,32'h2000,32'hDEADBEEF,1'b1,1'b0, 1'b1,1'b1,4'h3,32'h2000,4'b0010};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b1,4'h3,32'h300,32'h2000,32'hDEADBEEF,1'b0,1'b0, 1'b0,1'b0,4'h3,32'h2000,4'b0000};
    vecs[11] = '{1'b0,1'b1,1'b1,1'b1,4'h3,32'h300,32'h2000,32'hDEADBEEF,1'b1,1'b0, 1'b1,1'b0,4'hF,32'h300,4'b1000};
    vecs[12] = '{1'b0,1'b1,1'b1,1'b1,4'h3,32'h300,32'h2000,32'hDEADBEEF,1'b0,1'b0, 1'b0,1'b0,4'hF,32'h300,4'b0000};
    vecs[13] = '{1'b0,1'b1,1'b1,1'b1,4'h3,32'h300,32'h2000,32'hDEADBEEF,1'b0,1'b1, 1'b1,1'b1,4'h3,32'h2000,4'b0001};
    vecs[14] = '{1'b0,1'b1,1'b1,1'b1,4'h3,32'h300,32'h2000,32'hDEADBEEF,1'b0,1'b0, 1'b0,1'b0,4'h3,32'h2000,4'b0000};
    vecs[15] = '{1'b0,1'b1,1'b1,1'b1,4'h3,32'h300,32'h2000,32'hDEADBEEF,1'b1,1'b1, 1'b1,1'b0,4'hF,32'h300,4'b0100};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,1'b0, 1'b0,1'b0,4'hF,32'h300,4'b0000};

    for (int i = 0; i < 17; i++) begin
      reset = vecs[i].rst; instr_req = vecs[i].ireq; instr_addr = vecs[i].iaddr;
      data_req = vecs[i].dreq; data_we = vecs[i].dwe; data_be = vecs[i].dbe;
      data_addr = vecs[i].daddr; data_wdata = vecs[i].dwdata;
      bus_ack = vecs[i].back; bus_err = vecs[i].berr; bus_rdata = 32'h13;
      sample();
      check($sformatf("vec%0d", i),
            128'({bus_req, bus_we, bus_be, bus_addr, instr_ack, instr_err, data_ack, data_err}),
            128'({vecs[i].breq, vecs[i].bwe, vecs[i].bbe, vecs[i].baddr, vecs[i].acks}));
      if (vecs[i].acks[3]) check($sformatf("vec%0d_rdata", i), 128'(instr_rdata), 128'(32'h13));
      advance();
    end

    // watchdog: load that never gets a response
    idle_inputs();
    reset = 1'b1; sample(); advance(); reset = 1'b0;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h4000;
    sample(); advance();
    for (int k = 1; k <= TO; k++) begin
      sample();
      check($sformatf("to_busy%0d", k),
            128'({bus_req, data_ack, data_err, instr_ack, instr_err}),
            128'({1'b1, 1'b0, (k == TO), 1'b0, 1'b0}));
      advance();
    end
    data_req = 1'b0;
    sample();
    check("to_idle_req", 128'(bus_req), 128'(1'b0));
    advance();
    bus_ack = 1'b1;
    sample();
    check("to_late_ack", 128'({data_ack, data_err, instr_ack, instr_err}), 128'(4'b0000));
    advance();
    bus_ack = 1'b0;
    sample();
    check("to_late_ack_no_launch", 128'(bus_req), 128'(1'b0));
    advance();

    // reset in the middle of a store, then a tie must go to load/store again
    data_req = 1'b1; data_we = 1'b1; data_be = 4'hC; data_addr = 32'h5000; data_wdata = 32'h1234;
    sample(); advance();
    sample();
    check("rst_busy_req", 128'({bus_req, bus_we, bus_addr}), 128'({1'b1, 1'b1, 32'h5000}));
    advance();
    reset = 1'b1; bus_ack = 1'b1;
    sample();
    check("rst_no_resp", 128'({data_ack, data_err}), 128'(2'b00));
    advance();
    reset = 1'b0; bus_ack = 1'b0; instr_req = 1'b1; instr_addr = 32'h600;
    sample();
    check("rst_cleared", 128'({bus_req, bus_we, bus_addr}), 128'({1'b0, 1'b0, 32'h0}));
    advance();
    sample();
    check("rst_tie_data", 128'({bus_req, bus_we, bus_addr}), 128'({1'b1, 1'b1, 32'h5000}));
    bus_ack = 1'b1;
    advance();
    idle_inputs();
    sample(); advance();

    // address change and dropped req while a fetch is in flight
    instr_req = 1'b1; instr_addr = 32'h600;
    sample(); advance();
    instr_addr = 32'h700;
    sample();
    check("hold_addr1", 128'({bus_req, bus_addr}), 128'({1'b1, 32'h600}));
    advance();
    instr_req = 1'b0; instr_addr = 32'h800; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    sample();
    check("hold_addr2", 128'({bus_req, bus_addr}), 128'({1'b1, 32'h600}));
    check("hold_ack", 128'({instr_ack, instr_rdata, data_rdata}),
          128'({1'b1, 32'hCAFEF00D, 32'hCAFEF00D}));
    advance();
    idle_inputs();

    // random traffic against the reference model
    reset = 1'b1;
    model_eval(); model_step();
    sample(); advance();
    i_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!instr_req || (i_done && $urandom_range(0, 1) == 0)) begin
        instr_req  = (instr_req && i_done) ? 1'b1 : ($urandom_range(0, 2) == 0);
        instr_addr = $urandom;
      end else if (i_done) begin
        instr_req = 1'b0;
      end
      if (!data_req || (d_done && $urandom_range(0, 1) == 0)) begin
        data_req   = (data_req && d_done) ? 1'b1 : ($urandom_range(0, 2) == 0);
        data_we    = 1'($urandom_range(0, 1));
        data_be    = 4'($urandom_range(0, 15));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end else if (d_done) begin
        data_req = 1'b0;
      end
      bus_ack   = ($urandom_range(0, 3) == 0);
      bus_err   = ($urandom_range(0, 9) == 0);
      bus_rdata = $urandom;
      sample();
      model_eval();
      check($sformatf("rnd%0d_bus", c),
            128'({bus_req, bus_we, bus_be, bus_addr, bus_wdata}),
            128'({m_breq, m_bwe, m_bbe, m_baddr, m_bwdata}));
      check($sformatf("rnd%0d_resp", c),
            128'({instr_ack, instr_err, data_ack, data_err, instr_rdata, data_rdata}),
            128'({e_ia, e_ie, e_da, e_de, bus_rdata, bus_rdata}));
      i_done = e_ia || e_ie;
      d_done = e_da || e_de;
      model_step();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
